// File: rtl/pe_req_addr_dec_tracked_if.sv
// Bus bundle between one PE port and the per-slave arbitration trees.
// Signal names keep the decoder's own point of view: *_i enter the
// decoder, *_o leave it.
//   data_req_i / data_add_i       : PE request and address
//   data_gnt_o                    : grant back to the PE
//   data_r_valid_o/data_r_error_o : response (and decode-error flag) to the PE
//   data_req_o / data_ID_o        : one-hot request and constant ID to targets
//   data_gnt_i / data_r_valid_i   : per-target grants and responses
// Modport slave is the decoder view; modport master is the surrounding
// environment (PE plus targets) that drives the decoder inputs.
interface pe_req_addr_dec_tracked_if #(
  parameter int unsigned N_SLAVE    = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 17
);
  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_add_i;
  logic                  data_gnt_o;
  logic                  data_r_valid_o;
  logic                  data_r_error_o;
  logic [N_SLAVE-1:0]    data_req_o;
  logic [ID_WIDTH-1:0]   data_ID_o;
  logic [N_SLAVE-1:0]    data_gnt_i;
  logic [N_SLAVE-1:0]    data_r_valid_i;

  modport slave (
    input  data_req_i, data_add_i, data_gnt_i, data_r_valid_i,
    output data_gnt_o, data_r_valid_o, data_r_error_o, data_req_o, data_ID_o
  );

  modport master (
    output data_req_i, data_add_i, data_gnt_i, data_r_valid_i,
    input  data_gnt_o, data_r_valid_o, data_r_error_o, data_req_o, data_ID_o
  );
endinterface

// File: rtl/pe_req_addr_dec_tracked.sv
// PE request address decoder with outstanding-transaction tracking.
// Decodes the PE address into a one-hot request towards N_SLAVE targets
// (cluster region or optional alias region; everything else goes to target
// N_SLAVE-1), back-routes the selected grant, keeps responses in order by
// only letting the PE switch target once nothing is outstanding, and answers
// unmapped in-region indices with an internal one-cycle error response.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset
//   CLUSTER_ID : cluster index (static after reset), selects the home region
//   bus        : slave modport of pe_req_addr_dec_tracked_if (PE + target side)
module pe_req_addr_dec_tracked #(
  parameter int unsigned ID_WIDTH        = 17,
  parameter int unsigned ID              = 1,
  parameter int unsigned N_SLAVE         = 16,
  parameter int unsigned LOG_CLUSTER     = 5,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned REGION_MSB      = 31,
  parameter int unsigned REGION_LSB      = 20,
  parameter int unsigned ROUTING_MSB     = 19,
  parameter int unsigned ROUTING_LSB     = 16,
  parameter int unsigned PE_BASE         = 32'h102,
  parameter int unsigned CLUSTER_STRIDE  = 4,
  parameter int unsigned ALIAS_EN        = 1,
  parameter int unsigned ALIAS_BASE      = 32'h002,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LOG_CLUSTER-1:0] CLUSTER_ID,
  pe_req_addr_dec_tracked_if.slave bus
);

  localparam int unsigned RGN_W = REGION_MSB - REGION_LSB + 1;
  localparam int unsigned RT_W  = ROUTING_MSB - ROUTING_LSB + 1;
  // One extra code beyond the real targets encodes the internal error responder.
  localparam int unsigned TGT_W = $clog2(N_SLAVE + 1);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [TGT_W-1:0] TGT_ERR = TGT_W'(N_SLAVE);
  localparam logic [TGT_W-1:0] TGT_DEF = TGT_W'(N_SLAVE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TGT_W-1:0]   cur_tgt_q, cur_tgt_d;
  logic               err_pend_q, err_pend_d;

  logic [RGN_W-1:0]   field_s;
  logic [RGN_W-1:0]   home_s;
  logic [RT_W-1:0]    idx_raw_s;
  logic               in_region_s;
  logic               idx_oob_s;
  logic [TGT_W-1:0]   tgt_s;
  logic               tgt_err_s;
  logic               cur_err_s;
  logic               allowed_s;
  logic               sel_gnt_s;
  logic               sel_rvalid_s;
  logic [N_SLAVE-1:0] req_s;
  logic               gnt_s;
  logic               grant_fire_s;
  logic               rsp_s;

  // Region compare and routing index extraction.
  always_comb begin
    field_s   = bus.data_add_i[REGION_MSB:REGION_LSB];
    idx_raw_s = bus.data_add_i[ROUTING_MSB:ROUTING_LSB];
    // Home region wraps at region-field width.
    home_s    = RGN_W'(PE_BASE) + RGN_W'(CLUSTER_ID) * RGN_W'(CLUSTER_STRIDE);
    in_region_s = (field_s == home_s) ||
                  ((ALIAS_EN != 32'd0) && (field_s == RGN_W'(ALIAS_BASE)));
    idx_oob_s = (32'(idx_raw_s) >= N_SLAVE);
    if (!in_region_s) begin
      tgt_s = TGT_DEF;
    end else if (idx_oob_s) begin
      tgt_s = TGT_ERR;
    end else begin
      tgt_s = TGT_W'(idx_raw_s);
    end
    tgt_err_s = (tgt_s == TGT_ERR);
    cur_err_s = (cur_tgt_q == TGT_ERR);
    // A new target waits for the pipe to drain so responses stay in order.
    // Nothing is handed to the PE while reset is asserted.
    allowed_s = !rst && ((cnt_q == CNT_ZERO) ||
                         ((cnt_q < CNT_MAX) && (tgt_s == cur_tgt_q)));
  end

  // Request fan-out and grant/response selection for real targets.
  always_comb begin
    req_s        = {N_SLAVE{1'b0}};
    sel_gnt_s    = 1'b0;
    sel_rvalid_s = 1'b0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (tgt_s == TGT_W'(i)) begin
        req_s[i]  = bus.data_req_i & allowed_s;
        sel_gnt_s = bus.data_gnt_i[i];
      end else begin
        req_s[i]  = 1'b0;
      end
      if (cur_tgt_q == TGT_W'(i)) begin
        sel_rvalid_s = bus.data_r_valid_i[i];
      end else begin
        sel_rvalid_s = sel_rvalid_s;
      end
    end
  end

  // Grant back-routing, response selection and next-state computation.
  always_comb begin
    if (tgt_err_s) begin
      // Error responder accepts one transaction at a time.
      gnt_s = bus.data_req_i & allowed_s & !err_pend_q;
    end else begin
      gnt_s = sel_gnt_s & allowed_s;
    end
    grant_fire_s = bus.data_req_i & gnt_s;
    rsp_s = !rst && (cnt_q != CNT_ZERO) && (cur_err_s ? err_pend_q : sel_rvalid_s);

    case ({grant_fire_s, rsp_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    if (grant_fire_s) begin
      cur_tgt_d = tgt_s;
    end else begin
      cur_tgt_d = cur_tgt_q;
    end

    if (grant_fire_s && tgt_err_s) begin
      err_pend_d = 1'b1;
    end else if (rsp_s && cur_err_s) begin
      err_pend_d = 1'b0;
    end else begin
      err_pend_d = err_pend_q;
    end
  end

  // Tracking state: outstanding count, current target, pending error response.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= CNT_ZERO;
      cur_tgt_q  <= {TGT_W{1'b0}};
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_tgt_q  <= cur_tgt_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign bus.data_req_o     = req_s;
  assign bus.data_gnt_o     = gnt_s;
  assign bus.data_r_valid_o = rsp_s;
  assign bus.data_r_error_o = rsp_s & cur_err_s;
  assign bus.data_ID_o      = ID_WIDTH'(ID);

endmodule

// File: tb/tb_pe_req_addr_dec_tracked.sv
// Directed bench: instance A uses default parameters, instance B uses
// N_SLAVE=12, ALIAS_EN=0, MAX_OUTSTANDING=2. Both run with CLUSTER_ID=1,
// so the home region field is 0x106.
module tb_pe_req_addr_dec_tracked;

  logic       clk;
  logic       rst;
  logic [4:0] cluster_id;
  int         n_cmp;
  int         n_err;

  pe_req_addr_dec_tracked_if #(.N_SLAVE(16), .ADDR_WIDTH(32), .ID_WIDTH(17)) bus_a ();
  pe_req_addr_dec_tracked_if #(.N_SLAVE(12), .ADDR_WIDTH(32), .ID_WIDTH(17)) bus_b ();

  pe_req_addr_dec_tracked u_a (
    .clk        (clk),
    .rst        (rst),
    .CLUSTER_ID (cluster_id),
    .bus        (bus_a)
  );

  pe_req_addr_dec_tracked #(
    .N_SLAVE(12), .ALIAS_EN(0), .MAX_OUTSTANDING(2)
  ) u_b (
    .clk        (clk),
    .rst        (rst),
    .CLUSTER_ID (cluster_id),
    .bus        (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic req, input logic [31:0] add,
                       input logic [15:0] gnt, input logic [15:0] rv);
    bus_a.data_req_i     = req;
    bus_a.data_add_i     = add;
    bus_a.data_gnt_i     = gnt;
    bus_a.data_r_valid_i = rv;
    #1;
  endtask

  task automatic drv_b(input logic req, input logic [31:0] add,
                       input logic [11:0] gnt, input logic [11:0] rv);
    bus_b.data_req_i     = req;
    bus_b.data_add_i     = add;
    bus_b.data_gnt_i     = gnt;
    bus_b.data_r_valid_i = rv;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    cluster_id = 5'd1;
    drv_a(1'b0, 32'h0, 16'h0, 16'h0);
    drv_b(1'b0, 32'h0, 12'h0, 12'h0);
    tick();
    tick();

    // Reset state
    chk("rst_cnt_a",  32'(u_a.cnt_q), 32'd0);
    chk("rst_req_o",  32'(bus_a.data_req_o), 32'h0);
    chk("rst_gnt_o",  32'(bus_a.data_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(bus_a.data_r_valid_o), 32'd0);
    chk("rst_rerr",   32'(bus_a.data_r_error_o), 32'd0);
    chk("id_a",       32'(bus_a.data_ID_o), 32'd1);
    rst = 1'b0;

    // Two grants to slave 3, then grant+response, then responses
    drv_a(1'b1, 32'h1063_0000, 16'h0008, 16'h0);
    chk("s3_req_o",  32'(bus_a.data_req_o), 32'h0008);
    chk("s3_gnt1",   32'(bus_a.data_gnt_o), 32'd1);
    tick();
    chk("s3_cnt1",   32'(u_a.cnt_q), 32'd1);
    chk("s3_gnt2",   32'(bus_a.data_gnt_o), 32'd1);
    tick();
    chk("s3_cnt2",   32'(u_a.cnt_q), 32'd2);
    drv_a(1'b1, 32'h1063_0000, 16'h0008, 16'h0008);
    chk("s3_gr_gnt", 32'(bus_a.data_gnt_o), 32'd1);
    chk("s3_gr_rv",  32'(bus_a.data_r_valid_o), 32'd1);
    tick();
    chk("s3_cnt_gr", 32'(u_a.cnt_q), 32'd2);
    drv_a(1'b0, 32'h1063_0000, 16'h0, 16'h0008);
    chk("s3_rv1",    32'(bus_a.data_r_valid_o), 32'd1);
    chk("s3_rerr1",  32'(bus_a.data_r_error_o), 32'd0);
    tick();
    chk("s3_cnt3",   32'(u_a.cnt_q), 32'd1);
    chk("s3_rv2",    32'(bus_a.data_r_valid_o), 32'd1);
    tick();
    chk("s3_cnt4",   32'(u_a.cnt_q), 32'd0);
    drv_a(1'b0, 32'h1063_0000, 16'h0, 16'h0);
    chk("s3_rv_idle", 32'(bus_a.data_r_valid_o), 32'd0);

    // Alias region and out-of-region default target
    drv_a(1'b1, 32'h0025_0000, 16'h0, 16'h0);
    chk("alias_a_req", 32'(bus_a.data_req_o), 32'h0020);
    chk("alias_a_gnt", 32'(bus_a.data_gnt_o), 32'd0);
    drv_a(1'b1, 32'h2000_0000, 16'h0, 16'h0);
    chk("dflt_a_req",  32'(bus_a.data_req_o), 32'h8000);
    drv_a(1'b0, 32'h0, 16'h0, 16'h0);
    drv_b(1'b1, 32'h0025_0000, 12'h0, 12'h0);
    chk("alias_b_req", 32'(bus_b.data_req_o), 32'h0800);
    drv_b(1'b0, 32'h0, 12'h0, 12'h0);

    // Target switch stalls until the outstanding slave-3 access drains
    drv_a(1'b1, 32'h1063_0000, 16'h0008, 16'h0);
    tick();
    drv_a(1'b1, 32'h1065_0000, 16'h0020, 16'h0);
    chk("sw_req_stall", 32'(bus_a.data_req_o), 32'h0);
    chk("sw_gnt_stall", 32'(bus_a.data_gnt_o), 32'd0);
    tick();
    chk("sw_cnt_hold",  32'(u_a.cnt_q), 32'd1);
    drv_a(1'b1, 32'h1065_0000, 16'h0020, 16'h0008);
    chk("sw_req_rsp",   32'(bus_a.data_req_o), 32'h0);
    chk("sw_rv3",       32'(bus_a.data_r_valid_o), 32'd1);
    tick();
    drv_a(1'b1, 32'h1065_0000, 16'h0020, 16'h0);
    chk("sw_req_new",   32'(bus_a.data_req_o), 32'h0020);
    chk("sw_gnt_new",   32'(bus_a.data_gnt_o), 32'd1);
    tick();
    drv_a(1'b0, 32'h0, 16'h0, 16'h0008);
    chk("sw_ignore_rv", 32'(bus_a.data_r_valid_o), 32'd0);
    drv_a(1'b0, 32'h0, 16'h0, 16'h0020);
    chk("sw_rv5",       32'(bus_a.data_r_valid_o), 32'd1);
    tick();
    chk("sw_cnt_end",   32'(u_a.cnt_q), 32'd0);
    drv_a(1'b0, 32'h0, 16'h0, 16'h0);

    // Outstanding limit of 2 on instance B
    drv_b(1'b1, 32'h1063_0000, 12'h008, 12'h0);
    chk("max_gnt1",   32'(bus_b.data_gnt_o), 32'd1);
    tick();
    chk("max_gnt2",   32'(bus_b.data_gnt_o), 32'd1);
    tick();
    chk("max_cnt2",   32'(u_b.cnt_q), 32'd2);
    chk("max_gnt3",   32'(bus_b.data_gnt_o), 32'd0);
    chk("max_req3",   32'(bus_b.data_req_o), 32'h0);
    tick();
    chk("max_cnt_hold", 32'(u_b.cnt_q), 32'd2);
    drv_b(1'b1, 32'h1063_0000, 12'h008, 12'h008);
    chk("max_rsp_gnt", 32'(bus_b.data_gnt_o), 32'd0);
    chk("max_rsp_rv",  32'(bus_b.data_r_valid_o), 32'd1);
    tick();
    chk("max_cnt1",   32'(u_b.cnt_q), 32'd1);
    chk("max_gr_gnt", 32'(bus_b.data_gnt_o), 32'd1);
    tick();
    chk("max_gr_cnt", 32'(u_b.cnt_q), 32'd1);
    drv_b(1'b0, 32'h0, 12'h0, 12'h008);
    tick();
    chk("max_cnt0",   32'(u_b.cnt_q), 32'd0);

    // Unmapped in-region index 14 on a 12-target decoder
    drv_b(1'b1, 32'h106E_0000, 12'h0, 12'h0);
    chk("err_req_o",  32'(bus_b.data_req_o), 32'h0);
    chk("err_gnt",    32'(bus_b.data_gnt_o), 32'd1);
    chk("err_rv0",    32'(bus_b.data_r_valid_o), 32'd0);
    tick();
    chk("err_rv1",    32'(bus_b.data_r_valid_o), 32'd1);
    chk("err_rerr1",  32'(bus_b.data_r_error_o), 32'd1);
    chk("err_gnt_blk", 32'(bus_b.data_gnt_o), 32'd0);
    drv_b(1'b0, 32'h0, 12'h0, 12'h0);
    tick();
    chk("err_cnt0",   32'(u_b.cnt_q), 32'd0);
    chk("err_rv_off", 32'(bus_b.data_r_valid_o), 32'd0);
    chk("err_rerr_off", 32'(bus_b.data_r_error_o), 32'd0);

    // Reset with three outstanding; late response is dropped
    drv_a(1'b1, 32'h1063_0000, 16'h0008, 16'h0);
    tick();
    tick();
    tick();
    chk("rst3_cnt",   32'(u_a.cnt_q), 32'd3);
    rst = 1'b1;
    drv_a(1'b0, 32'h0, 16'h0, 16'h0);
    tick();
    rst = 1'b0;
    chk("rst3_cnt0",  32'(u_a.cnt_q), 32'd0);
    chk("rst3_req_o", 32'(bus_a.data_req_o), 32'h0);
    chk("rst3_gnt",   32'(bus_a.data_gnt_o), 32'd0);
    drv_a(1'b0, 32'h0, 16'h0, 16'h0008);
    chk("rst3_late_rv", 32'(bus_a.data_r_valid_o), 32'd0);
    chk("rst3_late_er", 32'(bus_a.data_r_error_o), 32'd0);
    drv_a(1'b0, 32'h0, 16'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
